fpa_entry_sequencer: RTL and testbench
======================================

// Module: fpa_entry_sequencer
// PURPOSE
//  Sequences the half-precision FP adder: collects operands A and B one hex nibble at a time,
//  launches the fpa, waits for done (with timeout) and latches the sum for display.
//  Sits between keypad decode/mode buttons and the fpa core; drives the 4-digit display word.
// PARAMETERS
//  TIMEOUT_CYC  1024  max cycles to wait for fpa_done before aborting (>=2)
//  NAN_CODE     16'h7E00  value latched as result on timeout
// PORTS
//  clk          in   1   system clock; the only clock
//  rst          in   1   synchronous, active-high reset
//  btn          in   4   one-hot mode: [0] clear, [1] enter A, [2] enter B, [3] compute
//  key_valid    in   1   one-cycle strobe: key_code holds a new hex digit
//  key_code     in   4   hex digit from keypad decoder
//  digit_sel    in   4   one-hot nibble position (bit0 -> [3:0] ... bit3 -> [15:12])
//  fpa_a        out  16  operand A to fpa
//  fpa_b        out  16  operand B to fpa
//  fpa_en       out  1   fpa start/enable, level
//  fpa_done     in   1   fpa completion, sampled each cycle
//  fpa_sum      in   16  fpa result, valid when fpa_done=1
//  disp_word    out  16  four hex digits for the 7-seg decoders
//  stage        out  2   00 idle, 01 entering A, 10 entering B, 11 compute/show
//  busy         out  1   high in START/WAIT
//  err          out  1   sticky timeout flag, cleared by clear or new compute
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; fpa_a=fpa_b=result=0; fpa_en=0; busy=0; err=0;
//   stage=00; disp_word=0; timeout counter=0. Reset mid-WAIT drops fpa_en next edge.
//  States: IDLE, ENT_A, ENT_B, START, WAIT, SHOW. All outputs registered.
//  btn not exactly one-hot (0 or >1 bits) -> no mode change. Clear has top priority:
//   btn=0001 in any state -> IDLE, A=B=result=0, err=0, fpa_en=0 next cycle.
//  btn=0010 -> ENT_A; btn=0100 -> ENT_B (from IDLE/ENT_A/ENT_B/SHOW; ignored in START/WAIT).
//  In ENT_A/ENT_B: key_valid=1 with one-hot digit_sel writes key_code into that nibble of A/B
//   the same edge; other nibbles hold. Non-one-hot digit_sel -> write ignored. Keys ignored
//   in all other states. Mode button and key_valid same cycle: write uses the OLD state.
//  btn=1000 from IDLE/ENT_A/ENT_B/SHOW -> START; err cleared. Operands frozen START..SHOW.
//  START: fpa_en=1, counter=0, busy=1, -> WAIT next cycle.
//  WAIT: fpa_en held 1; each cycle fpa_done=0 increments counter. fpa_done=1 -> result<=fpa_sum,
//   fpa_en<=0, -> SHOW. Counter reaching TIMEOUT_CYC-1 with no done -> result<=NAN_CODE,
//   err<=1, fpa_en<=0, -> SHOW. done on the timeout cycle wins (sum latched, err=0).
//  Latency: compute press edge N -> fpa_en high N+1 -> earliest result in SHOW at done edge+1.
//  SHOW: holds result; compute again re-launches with same operands.
//  disp_word: IDLE 0, ENT_A fpa_a, ENT_B fpa_b, START/WAIT fpa_b... no: START/WAIT 0, SHOW result.
//  stage: IDLE 00, ENT_A 01, ENT_B 10, START/WAIT/SHOW 11. busy=1 only START/WAIT.
//  Counter width = $clog2(TIMEOUT_CYC); saturates, never wraps.
// STRUCTURE
//  Shared package fpa_pkg: state enum (6 codes, 3 bits), stage codes, btn bit indices,
//   NAN_CODE default. One sub-module natural: nibble_loader (one-hot nibble write into a
//   16-bit register with enable), instantiated twice for A and B; FSM and timeout stay top.
// TESTING
//  Reset then btn=0010, keys 5@bit3,0@bit2,0@bit1,0@bit0 -> fpa_a=16'h5000, disp_word=5000, stage=01.
//  A=3C00, B=3C00, btn=1000, model done after 7 cycles with sum 4000 -> fpa_en high 8 cycles,
//   SHOW, disp_word=4000, err=0, stage=11.
//  TIMEOUT_CYC=16, fpa_done never rises -> fpa_en drops after 16 cycles, result=7E00, err=1.
//  btn=0001 mid-WAIT -> next cycle IDLE, fpa_en=0, fpa_a=fpa_b=0, disp_word=0, busy=0.
//  key_valid with digit_sel=0011 or btn=0110 -> no register/state change; keys in WAIT ignored.
//  btn=0100 and key_valid (digit_sel=0001, code A) same cycle from ENT_A -> A[3:0]=A, B unchanged.

Source files
------------

// File: rtl/fpa_pkg.sv
// Shared types and constants for the FP-adder entry sequencer: FSM state codes,
// display stage codes, mode-button bit positions and the default timeout result.
package fpa_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENT_A = 3'd1,
        S_ENT_B = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_SHOW  = 3'd5
    } state_e;

    localparam logic [1:0] STAGE_IDLE  = 2'b00;
    localparam logic [1:0] STAGE_ENT_A = 2'b01;
    localparam logic [1:0] STAGE_ENT_B = 2'b10;
    localparam logic [1:0] STAGE_RUN   = 2'b11;

    localparam int BTN_CLEAR   = 0;
    localparam int BTN_ENT_A   = 1;
    localparam int BTN_ENT_B   = 2;
    localparam int BTN_COMPUTE = 3;

    localparam logic [15:0] NAN_CODE_DEFAULT = 16'h7E00;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/fpa_entry_sequencer_if.sv
// Operand/result bus between the entry sequencer (master) and the fpa core (slave).
interface fpa_entry_sequencer_if;
    logic [15:0] fpa_a;
    logic [15:0] fpa_b;
    logic        fpa_en;
    logic        fpa_done;
    logic [15:0] fpa_sum;

    modport master (output fpa_a, fpa_b, fpa_en, input fpa_done, fpa_sum);
    modport slave  (input fpa_a, fpa_b, fpa_en, output fpa_done, fpa_sum);
endinterface

// File: rtl/fpa_entry_sequencer_nibble_loader.sv
// 16-bit operand register loaded one hex nibble at a time; exposes its next value
// so the parent can register a display word that tracks the write in the same edge.
module nibble_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        we,
    input  logic [3:0]  sel,
    input  logic [3:0]  din,
    output logic [15:0] q,
    output logic [15:0] q_nx
);

    // NOTE: combinational blocks assign every output first so no path infers a latch.
    always_comb begin
        q_nx = q;
        if (clr) begin
            q_nx = '0;
        end else if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) q_nx[i*4 +: 4] = din;
            end
        end
    end

    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= q_nx;
    end

endmodule

// File: rtl/fpa_entry_sequencer.sv
// Keypad/mode front end for the half-precision adder: nibble entry of A and B,
// launch with done-or-timeout wait, and a registered 4-digit display word.
module fpa_entry_sequencer
    import fpa_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [15:0] NAN_CODE    = NAN_CODE_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   btn,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    input  logic [3:0]                   digit_sel,
    fpa_entry_sequencer_if.master        fpa,
    output logic [15:0]                  disp_word,
    output logic [1:0]                   stage,
    output logic                         busy,
    output logic                         err
);

    localparam int            CW       = $clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_e        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [15:0]   result, result_nx;
    logic [15:0]   a_nx, b_nx, disp_nx;
    logic [1:0]    stage_nx;
    logic          en_nx, err_nx, busy_nx;

    logic btn_ok, clr_cmd, ent_a_cmd, ent_b_cmd, go_cmd;
    logic key_ok, a_we, b_we;

    assign btn_ok    = is_onehot4(btn);
    assign clr_cmd   = btn_ok && btn[BTN_CLEAR];
    assign ent_a_cmd = btn_ok && btn[BTN_ENT_A];
    assign ent_b_cmd = btn_ok && btn[BTN_ENT_B];
    assign go_cmd    = btn_ok && btn[BTN_COMPUTE];

    // Key writes are qualified by the current state, so a same-cycle mode press
    // never redirects the digit into the other operand.
    assign key_ok = key_valid && is_onehot4(digit_sel);
    assign a_we   = key_ok && (state == S_ENT_A);
    assign b_we   = key_ok && (state == S_ENT_B);

    nibble_loader u_load_a (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_cmd),
        .we   (a_we),
        .sel  (digit_sel),
        .din  (key_code),
        .q    (fpa.fpa_a),
        .q_nx (a_nx)
    );

    nibble_loader u_load_b (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_cmd),
        .we   (b_we),
        .sel  (digit_sel),
        .din  (key_code),
        .q    (fpa.fpa_b),
        .q_nx (b_nx)
    );

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        result_nx = result;
        en_nx     = fpa.fpa_en;
        err_nx    = err;

        if (clr_cmd) begin
            state_nx  = S_IDLE;
            cnt_nx    = '0;
            result_nx = '0;
            en_nx     = 1'b0;
            err_nx    = 1'b0;
        end else begin
            case (state)
                S_START: begin
                    en_nx    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = S_WAIT;
                end
                S_WAIT: begin
                    // done is checked first so it wins on the final timeout cycle
                    if (fpa.fpa_done) begin
                        result_nx = fpa.fpa_sum;
                        en_nx     = 1'b0;
                        state_nx  = S_SHOW;
                    end else if (cnt == CNT_LAST) begin
                        result_nx = NAN_CODE;
                        err_nx    = 1'b1;
                        en_nx     = 1'b0;
                        state_nx  = S_SHOW;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                S_IDLE, S_ENT_A, S_ENT_B, S_SHOW: begin
                    if (ent_a_cmd) begin
                        state_nx = S_ENT_A;
                    end else if (ent_b_cmd) begin
                        state_nx = S_ENT_B;
                    end else if (go_cmd) begin
                        state_nx = S_START;
                        err_nx   = 1'b0;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Display, stage and busy are decoded from the next state so they register
    // in step with the state they describe.
    always_comb begin
        disp_nx  = '0;
        stage_nx = STAGE_IDLE;
        busy_nx  = 1'b0;
        case (state_nx)
            S_ENT_A: begin
                disp_nx  = a_nx;
                stage_nx = STAGE_ENT_A;
            end
            S_ENT_B: begin
                disp_nx  = b_nx;
                stage_nx = STAGE_ENT_B;
            end
            S_START, S_WAIT: begin
                stage_nx = STAGE_RUN;
                busy_nx  = 1'b1;
            end
            S_SHOW: begin
                disp_nx  = result_nx;
                stage_nx = STAGE_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            result     <= '0;
            fpa.fpa_en <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            stage      <= STAGE_IDLE;
            disp_word  <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            result     <= result_nx;
            fpa.fpa_en <= en_nx;
            err        <= err_nx;
            busy       <= busy_nx;
            stage      <= stage_nx;
            disp_word  <= disp_nx;
        end
    end

endmodule

// File: tb/tb_fpa_entry_sequencer.sv
// Randomized bench for fpa_entry_sequencer with an operand/mode reference model
// and a behavioural fpa core that raises done a chosen number of cycles after launch.
module tb_fpa_entry_sequencer;

    localparam int          TO  = 16;
    localparam logic [15:0] NAN = 16'h7E00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = '0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = '0;
    logic [3:0]  digit_sel = '0;
    logic [15:0] disp_word;
    logic [1:0]  stage;
    logic        busy;
    logic        err;

    fpa_entry_sequencer_if fpa ();

    fpa_entry_sequencer #(.TIMEOUT_CYC(TO), .NAN_CODE(NAN)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digit_sel (digit_sel),
        .fpa       (fpa),
        .disp_word (disp_word),
        .stage     (stage),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // fpa core model: done rises once enable has been high for fpa_delay cycles
    int          fpa_delay   = 1000;
    int          en_count    = 0;
    logic [15:0] fpa_sum_val = '0;

    always @(posedge clk) en_count <= fpa.fpa_en ? en_count + 1 : 0;
    assign fpa.fpa_done = fpa.fpa_en && (en_count >= fpa_delay);
    assign fpa.fpa_sum  = fpa_sum_val;

    // reference model: mode 0 idle, 1 entering A, 2 entering B, 3 showing result
    int          m_mode = 0;
    logic [15:0] m_a = '0, m_b = '0, m_res = '0;
    logic        m_err = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_mode = 0; m_a = '0; m_b = '0; m_res = '0; m_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_disp;
        case (m_mode)
            1:       exp_disp = m_a;
            2:       exp_disp = m_b;
            3:       exp_disp = m_res;
            default: exp_disp = '0;
        endcase
        check({tag, "_a"},     fpa.fpa_a, m_a);
        check({tag, "_b"},     fpa.fpa_b, m_b);
        check({tag, "_stage"}, stage, m_mode);
        check({tag, "_disp"},  disp_word, exp_disp);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_en"},    fpa.fpa_en, 0);
        check({tag, "_err"},   err, m_err);
    endtask

    task automatic model_step(input logic [3:0] b, input logic kv,
                              input logic [3:0] code, input logic [3:0] sel);
        int          idx;
        logic [15:0] mask, val;
        if ($countones(b) == 1 && b[0]) begin
            model_clear();
            return;
        end
        if (kv && $countones(sel) == 1 && (m_mode == 1 || m_mode == 2)) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
            mask = 16'hF << (4 * idx);
            val  = {12'h000, code} << (4 * idx);
            if (m_mode == 1) m_a = (m_a & ~mask) | val;
            else             m_b = (m_b & ~mask) | val;
        end
        if ($countones(b) == 1) begin
            if (b[1])      m_mode = 1;
            else if (b[2]) m_mode = 2;
        end
    endtask

    task automatic cycle(input logic [3:0] b, input logic kv,
                         input logic [3:0] code, input logic [3:0] sel);
        btn = b; key_valid = kv; key_code = code; digit_sel = sel;
        tick();
        model_step(b, kv, code, sel);
        btn = '0; key_valid = 1'b0;
        check_all("cycle");
    endtask

    // launch a computation; clr_at >= 0 presses clear on that wait iteration
    task automatic run_compute(input int d, input logic [15:0] sum, input int clr_at);
        int  en_cycles;
        bit  done;
        fpa_delay = d; fpa_sum_val = sum;
        btn = 4'b1000;
        tick();
        btn = '0;
        check("start_busy",  busy, 1);
        check("start_en",    fpa.fpa_en, 0);
        check("start_stage", stage, 2'b11);
        check("start_disp",  disp_word, 0);
        check("start_err",   err, 0);
        en_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (i == clr_at) begin
                btn = 4'b0001; key_valid = 1'b0;
                tick();
                btn = '0;
                model_clear();
                check_all("clear_wait");
                return;
            end
            // mode buttons and keys while busy must be ignored
            btn = 4'b0010; key_valid = 1'b1; key_code = 4'hF; digit_sel = 4'b0001;
            tick();
            if (fpa.fpa_en) begin
                en_cycles++;
                check("wait_busy",  busy, 1);
                check("wait_stage", stage, 2'b11);
            end else begin
                done = 1'b1;
            end
        end
        btn = '0; key_valid = 1'b0;
        if (!done) check("en_bound", fpa.fpa_en, 0);
        check("en_cycles", en_cycles, (d < TO) ? d + 1 : TO);
        m_mode = 3;
        m_res  = (d < TO) ? sum : NAN;
        m_err  = (d >= TO);
        check_all("show");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] btn_pool [12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h4, 4'h6,
                                      4'h3, 4'h1, 4'h0, 4'h5};
        logic [3:0] sel_pool [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h0, 4'h1, 4'h2,
                                      4'h4, 4'h8};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        check_all("reset");

        // enter A = 5000 digit by digit
        cycle(4'b0010, 1'b0, 4'h0, 4'h0);
        cycle(4'b0000, 1'b1, 4'h5, 4'b1000);
        cycle(4'b0000, 1'b1, 4'h0, 4'b0100);
        cycle(4'b0000, 1'b1, 4'h0, 4'b0010);
        cycle(4'b0000, 1'b1, 4'h0, 4'b0001);
        check("spec_a",     fpa.fpa_a, 16'h5000);
        check("spec_disp",  disp_word, 16'h5000);
        check("spec_stage", stage, 2'b01);

        // A = B = 3C00, sum 4000 after 7 cycles
        cycle(4'b0000, 1'b1, 4'h3, 4'b1000);
        cycle(4'b0000, 1'b1, 4'hC, 4'b0100);
        cycle(4'b0100, 1'b0, 4'h0, 4'h0);
        cycle(4'b0000, 1'b1, 4'h3, 4'b1000);
        cycle(4'b0000, 1'b1, 4'hC, 4'b0100);
        cycle(4'b0000, 1'b1, 4'h0, 4'b0010);
        cycle(4'b0000, 1'b1, 4'h0, 4'b0001);
        run_compute(7, 16'h4000, -1);
        check("sum_disp", disp_word, 16'h4000);

        run_compute(40, 16'h1111, -1);
        check("timeout_disp", disp_word, 16'h7E00);
        check("timeout_err",  err, 1);
        run_compute(TO - 1, 16'h1234, -1);
        run_compute(TO, 16'h2345, -1);
        run_compute(0, 16'hBEEF, -1);

        // malformed selects and buttons, then mode press with a same-cycle key
        cycle(4'b0010, 1'b0, 4'h0, 4'h0);
        cycle(4'b0000, 1'b1, 4'h7, 4'b0011);
        cycle(4'b0110, 1'b1, 4'h9, 4'b0000);
        cycle(4'b0110, 1'b0, 4'h0, 4'h0);
        cycle(4'b0100, 1'b1, 4'hA, 4'b0001);
        check("same_cycle_a", fpa.fpa_a[3:0], 4'hA);

        // clear mid-wait
        run_compute(30, 16'h5555, 4);

        // reset mid-wait drops enable on the next edge
        fpa_delay = 100;
        btn = 4'b1000;
        tick();
        btn = '0;
        tick();
        tick();
        check("rst_wait_en", fpa.fpa_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check_all("rst_wait");

        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 49) begin
                run_compute($urandom_range(0, 20), 16'($urandom), -1);
            end else begin
                cycle(btn_pool[$urandom_range(0, 11)], 1'($urandom_range(0, 1)),
                      4'($urandom), sel_pool[$urandom_range(0, 9)]);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
